// File: rtl/mux2_vector_sequencer.sv
// Vector player for the 8-bit 2:1 operand mux. It buffers {s, d0, d1} vectors in a small FIFO
// and holds each one on registered outputs for a fixed number of cycles in which run is high.
module mux2_vector_sequencer #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             wr_en,
    input  logic [1:0]       wr_s,
    input  logic [WIDTH-1:0] wr_d0,
    input  logic [WIDTH-1:0] wr_d1,
    output logic             full,
    output logic             empty,
    output logic             wr_drop,
    output logic [1:0]       s,
    output logic [WIDTH-1:0] d0,
    output logic [WIDTH-1:0] d1,
    output logic             out_valid,
    output logic             vec_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int VW = 2 + 2 * WIDTH;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t            state, state_next;
    logic [VW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic [CW-1:0]     hold_cnt, cnt_next;
    logic              valid_next;
    logic              push, pop;
    logic [1:0]        head_s;
    logic [WIDTH-1:0]  head_d0, head_d1;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign {head_s, head_d0, head_d1} = mem[rd_ptr];

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {wr_s, wr_d0, wr_d1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && full;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            out_valid <= 1'b0;
            s         <= '0;
            d0        <= '0;
            d1        <= '0;
        end else begin
            state     <= state_next;
            hold_cnt  <= cnt_next;
            out_valid <= valid_next;
            if (pop) begin
                s  <= head_s;
                d0 <= head_d0;
                d1 <= head_d1;
            end
        end
    end

    // A pop always loads the head onto the outputs, so it doubles as the output load strobe.
    always_comb begin
        state_next = state;
        cnt_next   = hold_cnt;
        valid_next = out_valid;
        pop        = 1'b0;
        vec_done   = 1'b0;
        unique case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (run && !empty) begin
                    pop        = 1'b1;
                    valid_next = 1'b1;
                    cnt_next   = CW'(HOLD_CYCLES - 1);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (run) begin
                    if (hold_cnt != '0) begin
                        cnt_next = hold_cnt - CW'(1);
                    end else begin
                        vec_done = 1'b1;
                        if (!empty) begin
                            pop      = 1'b1;
                            cnt_next = CW'(HOLD_CYCLES - 1);
                        end else begin
                            valid_next = 1'b0;
                            state_next = IDLE;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux2_vector_sequencer.sv
// Bench for mux2_vector_sequencer. Accepted pushes queue their expected vectors, and a monitor
// pops the queue and compares each time a new vector shows up on the outputs.
module tb_mux2_vector_sequencer;

    localparam int WIDTH       = 8;
    localparam int DEPTH       = 4;
    localparam int HOLD_CYCLES = 4;

    typedef struct {
        logic [1:0]       s;
        logic [WIDTH-1:0] d0;
        logic [WIDTH-1:0] d1;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             wr_en;
    logic [1:0]       wr_s;
    logic [WIDTH-1:0] wr_d0, wr_d1;
    logic             full, empty, wr_drop;
    logic [1:0]       s;
    logic [WIDTH-1:0] d0, d1;
    logic             out_valid, vec_done;

    vec_t sbq[$];
    int   checks;
    int   fails;

    mux2_vector_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .wr_en(wr_en),
        .wr_s(wr_s), .wr_d0(wr_d0), .wr_d1(wr_d1),
        .full(full), .empty(empty), .wr_drop(wr_drop),
        .s(s), .d0(d0), .d1(d1),
        .out_valid(out_valid), .vec_done(vec_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drives one cycle of push stimulus; the vector is queued only when the push should be accepted.
    task automatic applyStimulus(input logic we, input logic [1:0] vs, input logic [WIDTH-1:0] v0,
                                 input logic [WIDTH-1:0] v1, input logic accept);
        vec_t v;
        wr_en = we;
        wr_s  = vs;
        wr_d0 = v0;
        wr_d1 = v1;
        if (we && accept) begin
            v.s  = vs;
            v.d0 = v0;
            v.d1 = v1;
            sbq.push_back(v);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // Monitor: a new vector is live when out_valid rises or follows a vec_done cycle.
    logic mon_prev_valid, mon_prev_done;
    int   mon_hold_len;
    always @(negedge clk) begin
        vec_t exp_v;
        if (!rst_n) begin
            mon_prev_valid = 1'b0;
            mon_prev_done  = 1'b0;
            mon_hold_len   = 0;
        end else begin
            if (out_valid && (!mon_prev_valid || mon_prev_done)) begin
                checkOutput("sb_pending", 32'(sbq.size() != 0), 1);
                if (sbq.size() != 0) begin
                    exp_v = sbq.pop_front();
                    checkOutput("sb_s", s, exp_v.s);
                    checkOutput("sb_d0", d0, exp_v.d0);
                    checkOutput("sb_d1", d1, exp_v.d1);
                end
                mon_hold_len = 0;
            end
            if (out_valid && run) begin
                mon_hold_len++;
            end
            if (vec_done) begin
                checkOutput("hold_len", mon_hold_len, HOLD_CYCLES);
            end
            mon_prev_valid = out_valid;
            mon_prev_done  = vec_done;
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vcnt;
        int dcnt;
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        run    = 1'b0;
        wr_en  = 1'b0;
        wr_s   = '0;
        wr_d0  = '0;
        wr_d1  = '0;

        // Reset while pushing: nothing may be retained.
        @(posedge clk); #1;
        applyStimulus(1'b1, 2'd3, 8'hAA, 8'h55, 1'b0);
        applyStimulus(1'b1, 2'd2, 8'hBB, 8'h66, 1'b0);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);
        checkOutput("rst_s", s, 0);
        checkOutput("rst_d0", d0, 0);
        checkOutput("rst_d1", d1, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_done", vec_done, 0);
        checkOutput("rst_drop", wr_drop, 0);
        checkOutput("rst_empty", empty, 1);
        checkOutput("rst_full", full, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("rst_no_retain_valid", out_valid, 0);
        checkOutput("rst_no_retain_empty", empty, 1);

        // Basic playback of four vectors.
        @(posedge clk); #1;
        run = 1'b0;
        applyStimulus(1'b1, 2'd0, 8'd5, 8'd10, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'd5, 8'd10, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'd255, 8'd127, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'd255, 8'd127, 1'b1);
        @(negedge clk);
        checkOutput("basic_full", full, 1);
        checkOutput("basic_empty", empty, 0);
        checkOutput("basic_idle_valid", out_valid, 0);
        @(posedge clk); #1;
        run  = 1'b1;
        vcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vcnt += int'(out_valid);
            dcnt += int'(vec_done);
        end
        checkOutput("basic_valid_cycles", vcnt, 16);
        checkOutput("basic_done_pulses", dcnt, 4);
        checkOutput("basic_end_valid", out_valid, 0);
        checkOutput("basic_end_empty", empty, 1);

        // Overflow: the fifth push is dropped.
        @(posedge clk); #1;
        run = 1'b0;
        applyStimulus(1'b1, 2'd1, 8'h01, 8'h02, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h03, 8'h04, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h05, 8'h06, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'h07, 8'h08, 1'b1);
        @(negedge clk);
        checkOutput("ovf_full", full, 1);
        checkOutput("ovf_no_drop_yet", wr_drop, 0);
        applyStimulus(1'b1, 2'd1, 8'hEE, 8'hDD, 1'b0);
        @(negedge clk);
        checkOutput("ovf_drop_pulse", wr_drop, 1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("ovf_drop_clear", wr_drop, 0);
        checkOutput("ovf_still_full", full, 1);
        @(posedge clk); #1;
        run = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        checkOutput("ovf_drained", sbq.size(), 0);
        checkOutput("ovf_end_valid", out_valid, 0);

        // Pause: run low for three cycles during the second hold cycle.
        @(posedge clk); #1;
        applyStimulus(1'b1, 2'd0, 8'd255, 8'd127, 1'b1);
        vcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            vcnt += int'(out_valid);
            dcnt += int'(vec_done);
            if (i >= 2 && i <= 4) begin
                checkOutput("pause_valid", out_valid, 1);
                checkOutput("pause_no_done", vec_done, 0);
                checkOutput("pause_s", s, 0);
                checkOutput("pause_d0", d0, 255);
                checkOutput("pause_d1", d1, 127);
            end
            @(posedge clk); #1;
            if (i == 1) run = 1'b0;
            if (i == 4) run = 1'b1;
        end
        checkOutput("pause_valid_cycles", vcnt, HOLD_CYCLES + 3);
        checkOutput("pause_done_pulses", dcnt, 1);

        // Push while full in the cycle the hold counter expires.
        run = 1'b0;
        applyStimulus(1'b1, 2'd0, 8'h10, 8'h20, 1'b1);
        applyStimulus(1'b1, 2'd1, 8'h11, 8'h21, 1'b1);
        applyStimulus(1'b1, 2'd2, 8'h12, 8'h22, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h13, 8'h23, 1'b1);
        run = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 1) checkOutput("sim_after_pop_full", full, 0);
            if (i == 2) checkOutput("sim_refilled_full", full, 1);
            if (i == 4) begin
                checkOutput("sim_done", vec_done, 1);
                checkOutput("sim_full_at_done", full, 1);
            end
            if (i == 5) begin
                checkOutput("sim_drop", wr_drop, 1);
                checkOutput("sim_full_clear", full, 0);
                checkOutput("sim_next_s", s, 1);
            end
            if (i == 6) begin
                checkOutput("sim_drop_clear", wr_drop, 0);
                checkOutput("sim_accept_full", full, 1);
            end
            if (i == 1)      applyStimulus(1'b1, 2'd0, 8'h14, 8'h24, 1'b1);
            else if (i == 4) applyStimulus(1'b1, 2'd1, 8'hF0, 8'hF1, 1'b0);
            else if (i == 5) applyStimulus(1'b1, 2'd2, 8'h15, 8'h25, 1'b1);
            else             applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
        end
        checkOutput("sim_drained", sbq.size(), 0);
        checkOutput("sim_end_valid", out_valid, 0);
        checkOutput("sim_end_empty", empty, 1);

        // Reset in the middle of the second vector.
        run = 1'b0;
        applyStimulus(1'b1, 2'd2, 8'h31, 8'h32, 1'b1);
        applyStimulus(1'b1, 2'd3, 8'h33, 8'h34, 1'b1);
        applyStimulus(1'b1, 2'd0, 8'h36, 8'h37, 1'b1);
        run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                checkOutput("mid_second_s", s, 3);
                checkOutput("mid_second_valid", out_valid, 1);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        sbq.delete();
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("midrst_s", s, 0);
        checkOutput("midrst_d0", d0, 0);
        checkOutput("midrst_d1", d1, 0);
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_done", vec_done, 0);
        checkOutput("midrst_empty", empty, 1);
        checkOutput("midrst_full", full, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 2'd1, 8'd5, 8'd10, 1'b1);
        @(negedge clk);
        checkOutput("post_push_valid", out_valid, 0);
        checkOutput("post_push_empty", empty, 0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("post_valid", out_valid, 1);
        checkOutput("post_s", s, 1);
        checkOutput("post_d0", d0, 5);
        checkOutput("post_d1", d1, 10);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
        end
        checkOutput("post_drained", sbq.size(), 0);
        checkOutput("post_end_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
